// File: rtl/adsr_vca.sv
// ADSR envelope generator feeding a VCA multiply: one shaped sample per strobe.
// Envelope/state update one cycle after the strobe, the scaled sample one cycle later.
module adsr_vca (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic               gate,
    input  logic [15:0]        attack_rate,
    input  logic [15:0]        decay_rate,
    input  logic [15:0]        sustain_level,
    input  logic [15:0]        release_rate,
    input  logic signed [23:0] wave_in,
    output logic signed [23:0] sample_out,
    output logic               sample_valid,
    output logic [15:0]        env_level,
    output logic [2:0]         env_state,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        env_q, env_d;
    logic signed [23:0] wave_q;
    logic               pend_q;
    logic signed [23:0] out_q;
    logic               valid_q;

    logic [16:0] attack_sum, decay_diff, release_diff;
    logic [15:0] attack_env, decay_env, release_env;
    logic        do_attack, do_release;

    // Candidate envelope values for each stage; bit 16 is carry/borrow.
    assign attack_sum   = {1'b0, env_q} + {1'b0, attack_rate};
    assign decay_diff   = {1'b0, env_q} - {1'b0, decay_rate};
    assign release_diff = {1'b0, env_q} - {1'b0, release_rate};

    assign attack_env  = (attack_rate == 16'd0 || attack_sum[16]) ? 16'hFFFF : attack_sum[15:0];
    assign decay_env   = (decay_rate == 16'd0 || decay_diff[16] || decay_diff[15:0] < sustain_level)
                         ? sustain_level : decay_diff[15:0];
    assign release_env = (release_rate == 16'd0 || release_diff[16]) ? 16'd0 : release_diff[15:0];

    // Gate fall wins over any stage completion.
    assign do_release = !gate && (state_q != S_IDLE);
    assign do_attack  = gate && (state_q == S_IDLE || state_q == S_ATTACK || state_q == S_RELEASE);

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (do_release) begin
            env_d   = release_env;
            state_d = (release_env == 16'd0) ? S_IDLE : S_RELEASE;
        end else if (do_attack) begin
            env_d   = attack_env;
            state_d = (attack_env == 16'hFFFF) ? S_DECAY : S_ATTACK;
        end else begin
            case (state_q)
                S_DECAY: begin
                    env_d   = decay_env;
                    state_d = (decay_env == sustain_level) ? S_SUSTAIN : S_DECAY;
                end
                S_SUSTAIN: begin
                    env_d   = sustain_level;
                    state_d = S_SUSTAIN;
                end
                default: begin
                    env_d   = 16'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // |wave| * env < 2^39, so a 40-bit signed product cannot overflow.
    logic signed [39:0] wave_ext, env_ext, product;
    assign wave_ext = {{16{wave_q[23]}}, wave_q};
    assign env_ext  = {24'd0, env_q};
    assign product  = wave_ext * env_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            env_q   <= 16'd0;
            wave_q  <= '0;
            pend_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= sample_en;
            valid_q <= pend_q;
            if (sample_en) begin
                state_q <= state_d;
                env_q   <= env_d;
                wave_q  <= wave_in;
            end
            if (pend_q) begin
                out_q <= product[39:16];
            end
        end
    end

    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign env_level    = env_q;
    assign env_state    = state_q;
    assign busy         = (state_q != S_IDLE);

endmodule
